// File: rtl/vjtag_axil_cmd_engine.sv
`timescale 1ns/1ps
// vjtag_axil_cmd_engine
// Virtual JTAG DR shift engine and single-slot command generator (tck domain).
// Each DR update under WRITE/READ becomes one bus command; read data and
// status return to the host through the DR (tdo) and the captured IR.
//
// Handshake: cmd_valid/cmd_ready follow strict valid/ready semantics. Once
// cmd_valid is high, cmd_write/cmd_addr/cmd_wdata stay stable until the
// cycle where cmd_ready is also high. After that cycle the engine waits for
// exactly one rsp_valid pulse. rsp_valid pulses outside that wait are ignored.
module vjtag_axil_cmd_engine #(
    parameter int              DATA_W   = 32,
    parameter int              IR_W     = 6,
    parameter logic [IR_W-1:0] I_ADDR   = 6'h01,
    parameter logic [IR_W-1:0] I_WRITE  = 6'h02,
    parameter logic [IR_W-1:0] I_READ   = 6'h03,
    parameter logic [IR_W-1:0] I_STATUS = 6'h04,
    parameter int              ADDR_INC = 4
) (
    input  logic              tck,
    input  logic              rst,
    input  logic              tdi,
    output logic              tdo,
    input  logic [IR_W-1:0]   ir_in,
    output logic [IR_W-1:0]   ir_out,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_udr,
    input  logic              virtual_state_uir,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_write,
    output logic [DATA_W-1:0] cmd_addr,
    output logic [DATA_W-1:0] cmd_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    input  logic              rsp_err
);

    // Command slot: IDLE (free), CMD (cmd_valid high), WAIT (awaiting rsp_valid)
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2
    } cmd_state_t;

    cmd_state_t state_q, state_d;

    logic [IR_W-1:0]   ir_reg;
    logic [DATA_W-1:0] sr;
    logic              bypass;
    logic [DATA_W-1:0] addr_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err, ovf, rd_valid;

    logic is_addr, is_write, is_read, is_status, is_bypass;
    logic wait_rsp, busy, slot_free, issue, accept_issue, drop_issue, complete;
    logic [3:0] status4;

    // Instruction decode; anything unrecognised selects the 1-bit bypass path
    always_comb begin
        is_addr   = (ir_reg == I_ADDR);
        is_write  = (ir_reg == I_WRITE);
        is_read   = (ir_reg == I_READ);
        is_status = (ir_reg == I_STATUS);
        is_bypass = !(is_addr || is_write || is_read || is_status);
    end

    // Slot status and command issue/drop/complete qualifiers
    always_comb begin
        cmd_valid    = (state_q == S_CMD);
        wait_rsp     = (state_q == S_WAIT);
        busy         = cmd_valid || wait_rsp;
        complete     = wait_rsp && rsp_valid;
        // A completion in the same cycle frees the slot for a back-to-back issue
        slot_free    = !busy || complete;
        issue        = virtual_state_udr && (is_write || is_read);
        accept_issue = issue && slot_free;
        drop_issue   = issue && !slot_free;
        status4      = {ovf, err, rd_valid, busy};
        ir_out       = IR_W'(status4);
        tdo          = is_bypass ? bypass : sr[0];
    end

    // Slot state register
    always_ff @(posedge tck or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Slot next-state: issue -> CMD, handshake -> WAIT, completion -> IDLE or CMD
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue) state_d = S_CMD;
            S_CMD:   if (cmd_ready) state_d = S_WAIT;
            S_WAIT:  if (rsp_valid) state_d = issue ? S_CMD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Instruction register and DR shift path (udr > cdr > sdr)
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            ir_reg <= '0;
            sr     <= '0;
            bypass <= 1'b0;
        end else begin
            if (virtual_state_uir) ir_reg <= ir_in;
            if (virtual_state_udr) begin
                // Update holds the shift register; actions happen elsewhere
            end else if (virtual_state_cdr) begin
                if (is_addr)        sr <= addr_reg;
                else if (is_write)  sr <= '0;
                else if (is_read)   sr <= rdata_reg;
                else if (is_status) sr <= DATA_W'(status4);
                else                bypass <= 1'b0;
            end else if (virtual_state_sdr) begin
                sr     <= {tdi, sr[DATA_W-1:1]};
                bypass <= tdi;
            end
        end
    end

    // Address, read data and sticky status; later assignments take priority
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            addr_reg  <= '0;
            rdata_reg <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            if (virtual_state_cdr && !virtual_state_udr && is_read) rd_valid <= 1'b0;
            if (virtual_state_udr && is_status && sr[0]) begin
                ovf <= 1'b0;
                err <= 1'b0;
            end
            if (drop_issue) ovf <= 1'b1;
            if (complete) begin
                addr_reg <= addr_reg + DATA_W'(ADDR_INC);
                if (rsp_err) err <= 1'b1;
                if (!cmd_write) begin
                    rdata_reg <= rsp_rdata;
                    rd_valid  <= 1'b1;
                end
            end
            // A host address write beats the post-transaction increment
            if (virtual_state_udr && is_addr) addr_reg <= sr;
        end
    end

    // Command payload latch; held stable while the slot is occupied
    always_ff @(posedge tck or posedge rst) begin
        if (rst) begin
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (accept_issue) begin
            cmd_write <= is_write;
            cmd_addr  <= addr_reg;
            if (is_write) cmd_wdata <= sr;
        end
    end

endmodule

// File: tb/tb_vjtag_axil_cmd_engine.sv
`timescale 1ns/1ps
// Directed bench for vjtag_axil_cmd_engine: drives virtual JTAG TAP states,
// plays the bus master side, and checks tdo, ir_out and commands.
module tb_vjtag_axil_cmd_engine;

    localparam int DATA_W = 32;
    localparam int IR_W   = 6;
    localparam logic [IR_W-1:0] I_ADDR   = 6'h01;
    localparam logic [IR_W-1:0] I_WRITE  = 6'h02;
    localparam logic [IR_W-1:0] I_READ   = 6'h03;
    localparam logic [IR_W-1:0] I_STATUS = 6'h04;
    localparam logic [IR_W-1:0] I_BYP    = 6'h3F;

    logic              tck = 1'b0;
    logic              rst;
    logic              tdi;
    logic              tdo;
    logic [IR_W-1:0]   ir_in;
    logic [IR_W-1:0]   ir_out;
    logic              cdr, sdr, udr, uir;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [DATA_W-1:0] cmd_addr, cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected commands: {write, addr, wdata}
    logic [2*DATA_W:0] exp_q[$];
    logic [DATA_W-1:0] dout;

    vjtag_axil_cmd_engine dut (
        .tck               (tck),
        .rst               (rst),
        .tdi               (tdi),
        .tdo               (tdo),
        .ir_in             (ir_in),
        .ir_out            (ir_out),
        .virtual_state_cdr (cdr),
        .virtual_state_sdr (sdr),
        .virtual_state_udr (udr),
        .virtual_state_uir (uir),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err)
    );

    // Clock
    always #5 tck = ~tck;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic set_ir(input logic [IR_W-1:0] code);
        @(negedge tck); ir_in = code; uir = 1'b1;
        @(negedge tck); uir = 1'b0;
    endtask

    // Capture, shift nbits LSB first, optionally update; dout = bits seen on tdo
    task automatic dr_scan(input logic [DATA_W-1:0] din, input int nbits,
                           input bit do_udr, output logic [DATA_W-1:0] dout_o);
        dout_o = '0;
        @(negedge tck); cdr = 1'b1;
        @(negedge tck); cdr = 1'b0; sdr = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            dout_o[i] = tdo;
            tdi = din[i];
            @(negedge tck);
        end
        sdr = 1'b0; tdi = 1'b0;
        if (do_udr) begin
            udr = 1'b1;
            @(negedge tck); udr = 1'b0;
        end
    endtask

    // Bus side: accept the pending command and compare against the scoreboard
    task automatic accept_cmd();
        logic [2*DATA_W:0] e;
        check("cmd_valid_pre", {31'd0, cmd_valid}, 32'd1);
        check("exp_q_nonempty", exp_q.size(), (exp_q.size() > 0) ? exp_q.size() : 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("cmd_write", {31'd0, cmd_write}, {31'd0, e[2*DATA_W]});
        check("cmd_addr", cmd_addr, e[2*DATA_W-1:DATA_W]);
        if (e[2*DATA_W]) check("cmd_wdata", cmd_wdata, e[DATA_W-1:0]);
        cmd_ready = 1'b1;
        @(negedge tck); cmd_ready = 1'b0;
        check("cmd_valid_post", {31'd0, cmd_valid}, 32'd0);
    endtask

    task automatic respond(input logic [DATA_W-1:0] rdata, input logic e);
        rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = e;
        @(negedge tck);
        rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tdi = 1'b0; ir_in = '0;
        cdr = 1'b0; sdr = 1'b0; udr = 1'b0; uir = 1'b0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
        repeat (3) @(negedge tck);
        check("rst_tdo", {31'd0, tdo}, 32'd0);
        check("rst_ir_out", {26'd0, ir_out}, 32'd0);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_cmd_addr", cmd_addr, 32'd0);
        rst = 1'b0;

        // Bypass: first bit is the captured 0, then tdi delayed one cycle
        set_ir(I_BYP);
        dr_scan(32'hFF, 8, 1'b1, dout);
        check("bypass_tdo", dout, 32'h0000_00FE);
        check("bypass_ir_out", {26'd0, ir_out}, 32'd0);
        check("bypass_cmd_valid", {31'd0, cmd_valid}, 32'd0);

        // Address then write
        set_ir(I_ADDR);
        dr_scan(32'h0000_1000, 32, 1'b1, dout);
        set_ir(I_WRITE);
        exp_q.push_back({1'b1, 32'h0000_1000, 32'hDEAD_BEEF});
        dr_scan(32'hDEAD_BEEF, 32, 1'b1, dout);
        check("wr_busy", {26'd0, ir_out}, 32'h01);
        accept_cmd();
        check("wr_wait_busy", {26'd0, ir_out}, 32'h01);
        respond(32'h0, 1'b0);
        check("wr_done_ir_out", {26'd0, ir_out}, 32'h00);
        set_ir(I_ADDR);
        dr_scan(32'h0, 32, 1'b0, dout);
        check("addr_after_wr", dout, 32'h0000_1004);

        // Pipelined reads
        set_ir(I_READ);
        exp_q.push_back({1'b1 ^ 1'b1, 32'h0000_1004, 32'h0});
        dr_scan(32'h0, 32, 1'b1, dout);
        check("rd1_shift_out", dout, 32'h0);
        accept_cmd();
        respond(32'h1234_5678, 1'b0);
        check("rd1_rd_valid", {26'd0, ir_out}, 32'h02);
        exp_q.push_back({1'b0, 32'h0000_1008, 32'h0});
        dr_scan(32'hFFFF_FFFF, 32, 1'b1, dout);
        check("rd2_shift_out", dout, 32'h1234_5678);
        check("rd2_rd_valid_clr", {26'd0, ir_out}, 32'h01);
        accept_cmd();
        respond(32'hA5A5_0000, 1'b0);

        // Overflow: second write while the first is held
        set_ir(I_WRITE);
        exp_q.push_back({1'b1, 32'h0000_100C, 32'h1111_1111});
        dr_scan(32'h1111_1111, 32, 1'b1, dout);
        dr_scan(32'h2222_2222, 32, 1'b1, dout);
        check("ovf_ir_out", {26'd0, ir_out}, 32'h0B);
        check("ovf_wdata_held", cmd_wdata, 32'h1111_1111);
        accept_cmd();
        respond(32'h0, 1'b0);
        check("ovf_done_ir_out", {26'd0, ir_out}, 32'h0A);
        set_ir(I_STATUS);
        dr_scan(32'h1, 32, 1'b1, dout);
        check("status_capture", dout, 32'h0000_000A);
        check("status_ovf_clr", {26'd0, ir_out}, 32'h02);

        // Address wrap with bus error
        set_ir(I_ADDR);
        dr_scan(32'hFFFF_FFFC, 32, 1'b1, dout);
        set_ir(I_WRITE);
        exp_q.push_back({1'b1, 32'hFFFF_FFFC, 32'h0000_CAFE});
        dr_scan(32'h0000_CAFE, 32, 1'b1, dout);
        accept_cmd();
        respond(32'h0, 1'b1);
        check("wrap_err_ir_out", {26'd0, ir_out}, 32'h06);
        set_ir(I_ADDR);
        dr_scan(32'h0, 32, 1'b0, dout);
        check("wrap_addr", dout, 32'h0);

        // Reset while waiting for a response, then a stray response
        set_ir(I_READ);
        exp_q.push_back({1'b0, 32'h0000_0000, 32'h0});
        dr_scan(32'h0, 32, 1'b1, dout);
        accept_cmd();
        rst = 1'b1;
        #1;
        check("midrst_ir_out", {26'd0, ir_out}, 32'h0);
        @(negedge tck); rst = 1'b0;
        respond(32'h0000_0BAD, 1'b1);
        check("stray_ir_out", {26'd0, ir_out}, 32'h0);
        check("stray_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        set_ir(I_READ);
        dr_scan(32'h0, 32, 1'b0, dout);
        check("stray_rdata", dout, 32'h0);
        set_ir(I_ADDR);
        dr_scan(32'h0, 32, 1'b0, dout);
        check("stray_addr", dout, 32'h0);

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
